ex_muldiv_seq: RTL and testbench

EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

---
 rtl/ex_muldiv_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ex_muldiv_seq                                              |
// | Description : Sequential RV32M multiply/divide unit for the EX stage.    |
// |               Radix-2 shift-add multiply and restoring divide, 32        |
// |               iterations each, followed by a one-cycle sign fix-up and   |
// |               a one-cycle done pulse.                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk           in   1  clock, rising edge                               |
// |   rst           in   1  asynchronous active-high reset                   |
// |   md_start_in   in   1  RV32M instruction in EX (level, held to done)    |
// |   md_op_in      in   3  func3 (MUL..REMU)                                |
// |   md_rs1_in     in  32  operand 1, sampled on acceptance                 |
// |   md_rs2_in     in  32  operand 2, sampled on acceptance                 |
// |   md_rd_in      in   5  destination register, sampled on acceptance     |
// |   md_flush_in   in   1  abort the current operation                      |
// |   md_stall_out  out  1  freeze PC, IF/ID, ID/EX                          |
// |   md_busy_out   out  1  operation in progress (MUL/DIV/FIX)              |
// |   md_done_out   out  1  one-cycle pulse, result valid                    |
// |   md_result_out out 32  result, held until the next completion          |
// |   md_rd_out     out  5  destination of md_result_out                     |
// +--------------------------------------------------------------------------+
// | Build option                                                             |
// |   MD_EARLY_OUT_EN : when defined, a multiply with a zero operand or a    |
// |                     divide by zero skips the iterations and goes         |
// |                     straight to FIX. Results are identical either way.   |
// +--------------------------------------------------------------------------+
module ex_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start_in,
  input  logic [2:0]  md_op_in,
  input  logic [31:0] md_rs1_in,
  input  logic [31:0] md_rs2_in,
  input  logic [4:0]  md_rd_in,
  input  logic        md_flush_in,
  output logic        md_stall_out,
  output logic        md_busy_out,
  output logic        md_done_out,
  output logic [31:0] md_result_out,
  output logic [4:0]  md_rd_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state, state_nxt;

  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q;     // final result must be two's-complement negated
  logic [4:0]  cnt;
  // hi:lo is the 64-bit product for MUL, remainder:quotient for DIV
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] bop;       // multiplicand magnitude or divisor magnitude

  // ---------------------------------------------------------------------
  // Start decode: signedness, magnitudes and result sign
  // ---------------------------------------------------------------------
  logic        accept;
  logic        s1_signed, s2_signed;
  logic        neg1, neg2;
  logic [31:0] mag1, mag2;
  logic        rs2_zero;
  logic        start_neg;
  logic        early;

  assign accept    = (state == IDLE) && md_start_in && !md_flush_in;
  // Only MULHU, DIVU and REMU treat rs1 as unsigned; MULHSU additionally
  // treats rs2 as unsigned.
  assign s1_signed = (md_op_in != 3'b011) && (md_op_in != 3'b101) &&
                     (md_op_in != 3'b111);
  assign s2_signed = s1_signed && (md_op_in != 3'b010);
  assign neg1      = s1_signed && md_rs1_in[31];
  assign neg2      = s2_signed && md_rs2_in[31];
  assign mag1      = neg1 ? (~md_rs1_in + 32'd1) : md_rs1_in;
  assign mag2      = neg2 ? (~md_rs2_in + 32'd1) : md_rs2_in;
  assign rs2_zero  = (md_rs2_in == 32'd0);

  // Remainder follows the dividend. The quotient sign is forced positive
  // on divide-by-zero so the all-ones magnitude passes through unchanged.
  always_comb begin
    start_neg = neg1 ^ neg2;
    if (md_op_in[2]) begin
      if (md_op_in[1]) start_neg = neg1;
      else             start_neg = (neg1 ^ neg2) && !rs2_zero;
    end
  end

`ifdef MD_EARLY_OUT_EN
  assign early = md_op_in[2] ? rs2_zero
                             : ((md_rs1_in == 32'd0) || rs2_zero);
`else
  assign early = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ok;
  logic [31:0] div_sub;

  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, bop} : 33'd0);
  assign div_shift = {hi, lo[31]};
  assign div_ok    = (div_shift >= {1'b0, bop});
  // When div_ok the true difference is below the divisor, so 32 bits hold it
  assign div_sub   = div_shift[31:0] - bop;

  // ---------------------------------------------------------------------
  // Fix-up: sign correction and result selection
  // ---------------------------------------------------------------------
  logic [63:0] prod_pos, prod_neg, prod_sel;
  logic [31:0] div_mag;
  logic [31:0] fix_result;

  assign prod_pos = {hi, lo};
  assign prod_neg = ~prod_pos + 64'd1;
  assign prod_sel = neg_q ? prod_neg : prod_pos;
  assign div_mag  = op_q[1] ? hi : lo;

  always_comb begin
    fix_result = 32'd0;
    if (!op_q[2]) begin
      fix_result = (op_q[1:0] == 2'b00) ? prod_sel[31:0] : prod_sel[63:32];
    end else begin
      fix_result = neg_q ? (~div_mag + 32'd1) : div_mag;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (early)            state_nxt = FIX;
          else if (md_op_in[2]) state_nxt = DIV;
          else                  state_nxt = MUL;
        end
      end
      MUL, DIV: begin
        if (md_flush_in)       state_nxt = IDLE;
        else if (cnt == 5'd31) state_nxt = FIX;
      end
      FIX: begin
        if (md_flush_in) state_nxt = IDLE;
        else             state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign md_busy_out  = (state == MUL) || (state == DIV) || (state == FIX);
  assign md_stall_out = md_busy_out || accept;
  assign md_done_out  = (state == DONE);

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= 3'd0;
      rd_q          <= 5'd0;
      neg_q         <= 1'b0;
      cnt           <= 5'd0;
      hi            <= 32'd0;
      lo            <= 32'd0;
      bop           <= 32'd0;
      md_result_out <= 32'd0;
      md_rd_out     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 5'd0;
          if (accept) begin
            op_q  <= md_op_in;
            rd_q  <= md_rd_in;
            neg_q <= start_neg;
            if (early) begin
              // Preload the values the iterations would have produced
              if (md_op_in[2]) begin
                hi <= mag1;
                lo <= 32'hFFFF_FFFF;
              end else begin
                hi <= 32'd0;
                lo <= 32'd0;
              end
            end else if (md_op_in[2]) begin
              hi  <= 32'd0;
              lo  <= mag1;
              bop <= mag2;
            end else begin
              hi  <= 32'd0;
              lo  <= mag2;
              bop <= mag1;
            end
          end
        end
        MUL: begin
          cnt <= md_flush_in ? 5'd0 : cnt + 5'd1;
          hi  <= mul_sum[32:1];
          lo  <= {mul_sum[0], lo[31:1]};
        end
        DIV: begin
          cnt <= md_flush_in ? 5'd0 : cnt + 5'd1;
          hi  <= div_ok ? div_sub : div_shift[31:0];
          lo  <= {lo[30:0], div_ok};
        end
        FIX: begin
          if (!md_flush_in) begin
            md_result_out <= fix_result;
            md_rd_out     <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ex_muldiv_seq                                           |
// | Description : Self-checking bench for ex_muldiv_seq. Directed corner     |
// |               cases plus randomized operations compared against an       |
// |               arithmetic reference model. Edge N is the rising edge      |
// |               after which md_start_in is raised.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_result = 32'd0;
  logic [4:0]  last_rd     = 5'd0;

  always #5 clk = ~clk;

  ex_muldiv_seq dut (
    .clk           (clk),
    .rst           (rst),
    .md_start_in   (start),
    .md_op_in      (op),
    .md_rs1_in     (rs1),
    .md_rs2_in     (rs2),
    .md_rd_in      (rd),
    .md_flush_in   (flush),
    .md_stall_out  (stall),
    .md_busy_out   (busy),
    .md_done_out   (done),
    .md_result_out (result),
    .md_rd_out     (rd_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: RV32M semantics with plain 64-bit / 32-bit arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    p  = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MD_EARLY_OUT_EN
    if (f[2] ? (b == 32'd0) : (a == 32'd0 || b == 32'd0)) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // One full operation; start held through the DONE cycle
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d);
    int lat;
    logic stall_ok;
    logic [31:0] exp;
    exp = ref_md(f, a, b);
    @(posedge clk); #1;
    start = 1'b1; op = f; rs1 = a; rs2 = b; rd = d;
    lat = 0;
    #1;
    stall_ok = stall;
    while (!done && lat < 40) begin
      @(posedge clk); lat++; #1;
      if (lat == 1) begin
        // operands must have been captured already
        rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom);
      end
      if (!done && !stall) stall_ok = 1'b0;
    end
    chk("latency",    32'(lat), 32'(ref_lat(f, a, b)));
    chk("result",     result, exp);
    chk("rd",         {27'd0, rd_out}, {27'd0, d});
    chk("stall_busy", {31'd0, stall_ok}, 32'd1);
    chk("stall_done", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("no_relaunch", {31'd0, busy}, 32'd0);
    chk("done_pulse",  {31'd0, done}, 32'd0);
    last_result = exp;
    last_rd     = d;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; rs1 = 32'd0; rs2 = 32'd0; rd = 5'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall",  {31'd0, stall}, 32'd0);
    chk("rst_busy",   {31'd0, busy},  32'd0);
    chk("rst_done",   {31'd0, done},  32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd",     {27'd0, rd_out}, 32'd0);
    rst = 1'b0;

    // Directed corner cases
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1);
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2);
    run_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3);
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4);
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd5);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6);
    run_op(3'd5, 32'd100,        32'd7,         5'd7);
    run_op(3'd4, 32'd5,          32'd0,         5'd8);
    run_op(3'd7, 32'd5,          32'd0,         5'd9);
    run_op(3'd6, 32'hFFFF_FFF9,  32'd0,         5'd10);
    run_op(3'd0, 32'd0,          32'h1234_5678, 5'd11);

    // Flush mid-divide: no done, outputs retained, next op normal
    begin
      int lat;
      logic saw_done;
      @(posedge clk); #1;
      start = 1'b1; op = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd20;
      lat = 0; saw_done = 1'b0;
      while (lat < 10) begin @(posedge clk); lat++; #1; saw_done |= done; end
      flush = 1'b1;
      @(posedge clk); #1;
      chk("flush_busy",   {31'd0, busy}, 32'd0);
      chk("flush_done",   {31'd0, done | saw_done}, 32'd0);
      chk("flush_result", result, last_result);
      chk("flush_rd",     {27'd0, rd_out}, {27'd0, last_rd});
      flush = 1'b0; start = 1'b0;
      run_op(3'd5, 32'd1000, 32'd3, 5'd21);
    end

    // Flush and start together in IDLE: nothing starts
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
    #1;
    chk("flush_start_stall", {31'd0, stall}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; flush = 1'b0;

    // Reset mid-multiply
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; rs1 = 32'd9; rs2 = 32'd9; rd = 5'd30;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'd0, busy},  32'd0);
    chk("mid_rst_stall",  {31'd0, stall}, 32'd0);
    chk("mid_rst_done",   {31'd0, done},  32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_rd",     {27'd0, rd_out}, 32'd0);
    begin
      logic saw_done;
      saw_done = 1'b0;
      repeat (40) begin @(posedge clk); #1; saw_done |= done; end
      chk("mid_rst_no_done", {31'd0, saw_done}, 32'd0);
    end
    rst = 1'b0;

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
